// File: rtl/spi_peripheral.sv
// SPI responder: full-duplex, MSb-first 8-bit frames between external SPI pins and an on-chip byte port.
// Latency: pins are 2-FF synchronised, edges act 3 i_Clk cycles after the pin; o_RX_DV one cycle after the 8th sample.
// Backpressure: one-deep TX holding register (o_TX_Ready); IDLE_TX_BYTE is sent when it is empty at a byte boundary.
// Optional feature macro: SPI_PERIPH_MISO_TRISTATE_EN adds the o_SPI_MISO_En pad enable output.
module spi_peripheral #(
    parameter int         SPI_MODE     = 0,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
    output logic       o_SPI_MISO_En,
`endif
    output logic       o_SPI_MISO
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       sck_s1, sck_s2, sck_s3;
    logic       cs_s1, cs_s2, cs_s3;
    logic       mosi_s1, mosi_s2;

    logic [7:0] hold_q;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       byte_end;

    logic       lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       cs_fall, cs_rise;
    logic       frame_load, active;
    logic       do_sample, do_shift, byte_reload, load;
    logic [7:0] load_src;

    // Synchroniser chains; the third SCK/CS_n stage gives the previous value for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_s1  <= CPOL;
            sck_s2  <= CPOL;
            sck_s3  <= CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= i_SPI_Clk;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= i_SPI_CS_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            mosi_s1 <= i_SPI_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // Edge decode: leading edge leaves the idle (CPOL) level, trailing edge returns to it
    always_comb begin
        lead_edge   = (sck_s2 != CPOL) && (sck_s3 == CPOL);
        trail_edge  = (sck_s2 == CPOL) && (sck_s3 != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        cs_fall     = !cs_s2 && cs_s3;
        cs_rise     = cs_s2 && !cs_s3;
    end

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_d    = state_q;
        frame_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_ACTIVE;
                    frame_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        active      = (state_q == ST_ACTIVE);
        // A sample coinciding with CS_n rising still counts so an exact 8th bit completes the byte
        do_sample   = active && sample_edge;
        // Shifting is suppressed when CS_n rises so an aborted frame never consumes the holding reg
        do_shift    = active && shift_edge && !cs_rise;
        byte_reload = do_shift && byte_end;
        load        = frame_load || byte_reload;
        load_src    = o_TX_Ready ? IDLE_TX_BYTE : hold_q;
    end

    // TX holding register, TX/RX shifters, bit counter and MISO drive
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_TX_Ready <= 1'b1;
            hold_q     <= 8'h00;
            tx_shift   <= 8'h00;
            rx_shift   <= 7'h00;
            bit_cnt    <= 3'd7;
            byte_end   <= 1'b0;
            o_RX_DV    <= 1'b0;
            o_RX_Byte  <= 8'h00;
            o_SPI_MISO <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;

            // A reload drains a full holding reg; otherwise a new byte may be queued, even alongside a reload
            if (load && !o_TX_Ready) begin
                o_TX_Ready <= 1'b1;
            end else if (i_TX_DV && o_TX_Ready) begin
                hold_q     <= i_TX_Byte;
                o_TX_Ready <= 1'b0;
            end

            if (frame_load) begin
                bit_cnt  <= 3'd7;
                byte_end <= 1'b0;
                if (!CPHA) begin
                    o_SPI_MISO <= load_src[7];
                    tx_shift   <= {load_src[6:0], 1'b0};
                end else begin
                    tx_shift <= load_src;
                end
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[5:0], mosi_s2};
                if (bit_cnt == 3'd0) begin
                    o_RX_Byte <= {rx_shift, mosi_s2};
                    o_RX_DV   <= 1'b1;
                    bit_cnt   <= 3'd7;
                    byte_end  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                end
            end

            if (do_shift) begin
                if (byte_reload) begin
                    o_SPI_MISO <= load_src[7];
                    tx_shift   <= {load_src[6:0], 1'b0};
                    byte_end   <= 1'b0;
                end else begin
                    o_SPI_MISO <= tx_shift[7];
                    tx_shift   <= {tx_shift[6:0], 1'b0};
                end
            end

            // End of frame: drop any partial byte and park MISO low
            if (active && cs_rise) begin
                bit_cnt    <= 3'd7;
                byte_end   <= 1'b0;
                o_SPI_MISO <= 1'b0;
            end
        end
    end

`ifdef SPI_PERIPH_MISO_TRISTATE_EN
    assign o_SPI_MISO_En = (state_q == ST_ACTIVE);
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: one instance per SPI mode behind a shared master model.
// Master runs SCK with a 4-cycle half period; only the selected instance sees CS_n low.
// Each step compares DUT outputs against hand-computed values.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_byte;
    logic [3:0] tx_dv;
    logic       sck_base;
    logic       cs_raw;
    logic       mosi;
    int         sel;

    logic [3:0] sck;
    logic [3:0] cs_n;
    logic [3:0] miso;
    logic [3:0] tx_ready;
    logic [3:0] rx_dv;
    logic [7:0] rx_byte [4];
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
    logic [3:0] miso_en;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int rx_cnt [4]  = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    assign sck[0]  = sck_base;
    assign sck[1]  = sck_base;
    assign sck[2]  = ~sck_base;
    assign sck[3]  = ~sck_base;
    assign cs_n[0] = cs_raw | (sel != 0);
    assign cs_n[1] = cs_raw | (sel != 1);
    assign cs_n[2] = cs_raw | (sel != 2);
    assign cs_n[3] = cs_raw | (sel != 3);

    spi_peripheral #(.SPI_MODE(0)) u_m0 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[0]),
        .o_TX_Ready(tx_ready[0]), .o_RX_DV(rx_dv[0]), .o_RX_Byte(rx_byte[0]),
        .i_SPI_Clk(sck[0]), .i_SPI_CS_n(cs_n[0]), .i_SPI_MOSI(mosi),
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
        .o_SPI_MISO_En(miso_en[0]),
`endif
        .o_SPI_MISO(miso[0]));

    spi_peripheral #(.SPI_MODE(1)) u_m1 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[1]),
        .o_TX_Ready(tx_ready[1]), .o_RX_DV(rx_dv[1]), .o_RX_Byte(rx_byte[1]),
        .i_SPI_Clk(sck[1]), .i_SPI_CS_n(cs_n[1]), .i_SPI_MOSI(mosi),
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
        .o_SPI_MISO_En(miso_en[1]),
`endif
        .o_SPI_MISO(miso[1]));

    spi_peripheral #(.SPI_MODE(2)) u_m2 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[2]),
        .o_TX_Ready(tx_ready[2]), .o_RX_DV(rx_dv[2]), .o_RX_Byte(rx_byte[2]),
        .i_SPI_Clk(sck[2]), .i_SPI_CS_n(cs_n[2]), .i_SPI_MOSI(mosi),
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
        .o_SPI_MISO_En(miso_en[2]),
`endif
        .o_SPI_MISO(miso[2]));

    spi_peripheral #(.SPI_MODE(3)) u_m3 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[3]),
        .o_TX_Ready(tx_ready[3]), .o_RX_DV(rx_dv[3]), .o_RX_Byte(rx_byte[3]),
        .i_SPI_Clk(sck[3]), .i_SPI_CS_n(cs_n[3]), .i_SPI_MOSI(mosi),
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
        .o_SPI_MISO_En(miso_en[3]),
`endif
        .o_SPI_MISO(miso[3]));

    // Count o_RX_DV pulses per instance
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_dv[i]) rx_cnt[i] <= rx_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_tx(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
    endtask

    // SPI master: shifts nbits of d MSb-first from d[15], captures MISO into rd the same way
    task automatic spi_frame(input int m, input logic [15:0] d, input int nbits, output logic [15:0] rd);
        logic cpha;
        cpha     = (m == 1) || (m == 3);
        rd       = 16'h0000;
        sel      = m;
        sck_base = 1'b0;
        @(negedge clk);
        cs_raw = 1'b0;
        if (!cpha) mosi = d[15];
        half();
        half();
        for (int i = 0; i < nbits; i++) begin
            if (cpha) mosi = d[15-i];
            else rd[15-i] = miso[m];
            sck_base = 1'b1;
            half();
            if (cpha) rd[15-i] = miso[m];
            else if (i < nbits - 1) mosi = d[14-i];
            sck_base = 1'b0;
            half();
        end
        cs_raw = 1'b1;
        mosi   = 1'b0;
        half();
        half();
    endtask

    initial begin
        logic [15:0] rd;
        int          c;

        rst_n    = 1'b0;
        tx_byte  = 8'h00;
        tx_dv    = 4'h0;
        sck_base = 1'b0;
        cs_raw   = 1'b1;
        mosi     = 1'b0;
        sel      = 0;
        repeat (3) @(negedge clk);

        check("rst_tx_ready", {12'h0, tx_ready}, 16'h000F);
        check("rst_rx_dv", {12'h0, rx_dv}, 16'h0000);
        check("rst_rx_byte", {8'h0, rx_byte[0]}, 16'h0000);
        check("rst_miso", {12'h0, miso}, 16'h0000);
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
        check("rst_miso_en", {12'h0, miso_en}, 16'h0000);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0: slave sends A5, master sends 3C
        pulse_tx(0, 8'hA5);
        check("m0_queued_ready", {15'h0, tx_ready[0]}, 16'h0000);
        c = rx_cnt[0];
        spi_frame(0, 16'h3C00, 8, rd);
        check("m0_master_rx", {8'h0, rd[15:8]}, 16'h00A5);
        check("m0_rx_byte", {8'h0, rx_byte[0]}, 16'h003C);
        check("m0_rx_pulses", 16'(rx_cnt[0] - c), 16'd1);
        check("m0_ready_after", {15'h0, tx_ready[0]}, 16'h0001);

        // Modes 1..3: slave sends 81, master sends 7E
        for (int m = 1; m < 4; m++) begin
            pulse_tx(m, 8'h81);
            c = rx_cnt[m];
            spi_frame(m, 16'h7E00, 8, rd);
            check($sformatf("m%0d_master_rx", m), {8'h0, rd[15:8]}, 16'h0081);
            check($sformatf("m%0d_rx_byte", m), {8'h0, rx_byte[m]}, 16'h007E);
            check($sformatf("m%0d_rx_pulses", m), 16'(rx_cnt[m] - c), 16'd1);
        end

        // Nothing queued, two bytes in one frame: idle byte twice
        c = rx_cnt[0];
        spi_frame(0, 16'h0102, 16, rd);
        check("idle_master_rx", rd, 16'hFFFF);
        check("idle_rx_pulses", 16'(rx_cnt[0] - c), 16'd2);
        check("idle_rx_byte", {8'h0, rx_byte[0]}, 16'h0002);

        // 11 queued before the frame, 22 queued during byte 0, 33 must be dropped
        pulse_tx(0, 8'h11);
        fork
            spi_frame(0, 16'h5A96, 16, rd);
            begin
                repeat (20) @(negedge clk);
                check("q_ready_after_load", {15'h0, tx_ready[0]}, 16'h0001);
                pulse_tx(0, 8'h22);
                check("q_ready_full", {15'h0, tx_ready[0]}, 16'h0000);
                pulse_tx(0, 8'h33);
            end
        join
        check("q_master_rx", rd, 16'h1122);
        check("q_rx_byte", {8'h0, rx_byte[0]}, 16'h0096);
        spi_frame(0, 16'h6600, 8, rd);
        check("q_dropped", {8'h0, rd[15:8]}, 16'h00FF);
        check("q_rx_byte2", {8'h0, rx_byte[0]}, 16'h0066);

        // Aborted frame after 5 bits, then a full C3 frame
        c = rx_cnt[0];
        spi_frame(0, 16'hF000, 5, rd);
        check("abort_rx_pulses", 16'(rx_cnt[0] - c), 16'd0);
        check("abort_rx_byte", {8'h0, rx_byte[0]}, 16'h0066);
        spi_frame(0, 16'hC300, 8, rd);
        check("after_abort_rx_byte", {8'h0, rx_byte[0]}, 16'h00C3);
        check("after_abort_pulses", 16'(rx_cnt[0] - c), 16'd1);
        check("after_abort_master", {8'h0, rd[15:8]}, 16'h00FF);

        // Reset asserted mid-byte with a byte queued
        c = rx_cnt[0];
        fork
            spi_frame(0, 16'h5500, 8, rd);
            begin
                repeat (30) @(negedge clk);
                pulse_tx(0, 8'h77);
                check("mid_ready_full", {15'h0, tx_ready[0]}, 16'h0000);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_ready", {15'h0, tx_ready[0]}, 16'h0001);
                check("mid_rst_rx_byte", {8'h0, rx_byte[0]}, 16'h0000);
                check("mid_rst_miso", {15'h0, miso[0]}, 16'h0000);
                check("mid_rst_rx_dv", {15'h0, rx_dv[0]}, 16'h0000);
`ifdef SPI_PERIPH_MISO_TRISTATE_EN
                check("mid_rst_miso_en", {15'h0, miso_en[0]}, 16'h0000);
`endif
            end
        join
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_pulses", 16'(rx_cnt[0] - c), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
